// File: rtl/fifo_read_interface.sv
// fifo_read_interface: AXI4 read master that fetches num_elements 32-bit words
// starting at addr_offset and forwards them one at a time onto an AXI-Stream
// link to a downstream FIFO. Bursts are split into at most 256 beats.
// Optional feature macro RD_RESP_CHECK_EN: when defined, RRESP errors and RLAST
// mismatches set the sticky rd_error flag; when undefined rd_error is tied 0.

module fifo_read_interface #(
    parameter int NUM_ELEMENTS_WIDTH = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          rst_busy,

    output logic [31:0]                   M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,

    input  logic [31:0]                   addr_offset,
    input  logic [NUM_ELEMENTS_WIDTH-1:0] num_elements,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_error,

    output logic [1:0]                    M_AXI_ARID,
    output logic [31:0]                   M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARQOS,

    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        AR_WAIT,
        R_WAIT,
        PUSH,
        CHECK
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic [31:0]                   base_addr;
    logic [NUM_ELEMENTS_WIDTH-1:0] total_elements;
    logic [NUM_ELEMENTS_WIDTH-1:0] element_counter;
    logic [NUM_ELEMENTS_WIDTH-1:0] remaining;
    logic [7:0]                    beat_counter;
    logic                          last_beat;

    // Fixed AR attributes: single-ID, 4-byte incrementing bursts, normal access.
    assign M_AXI_ARID    = 2'b00;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0010;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;

    // The beat counter alone decides where a burst ends; RLAST is only checked.
    assign remaining = total_elements - element_counter;
    assign last_beat = (beat_counter == M_AXI_ARLEN);

`ifndef RD_RESP_CHECK_EN
    logic unused_resp;
    assign unused_resp = ^{M_AXI_RRESP, M_AXI_RLAST};
`endif

    // State register; rst_busy freezes the sequencer in place.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else if (!rst_busy) begin
            state <= next_state;
        end
    end

    // Next-state decisions, one handshake per transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (num_elements == '0) ? CHECK : SETUP;
            SETUP:   next_state = AR_WAIT;
            AR_WAIT: if (M_AXI_ARREADY) next_state = R_WAIT;
            R_WAIT:  if (M_AXI_RVALID) next_state = PUSH;
            PUSH:    if (M_AXIS_TREADY) next_state = last_beat ? CHECK : R_WAIT;
            CHECK:   next_state = (element_counter == total_elements) ? IDLE : SETUP;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs, counters and the single-beat holding register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            base_addr       <= '0;
            total_elements  <= '0;
            element_counter <= '0;
            beat_counter    <= '0;
            M_AXI_ARADDR    <= '0;
            M_AXI_ARLEN     <= '0;
            M_AXI_ARVALID   <= 1'b0;
            M_AXI_RREADY    <= 1'b0;
            M_AXIS_TDATA    <= '0;
            M_AXIS_TVALID   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            rd_error        <= 1'b0;
        end else if (!rst_busy) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr      <= addr_offset;
                        total_elements <= num_elements;
                        busy           <= 1'b1;
                        rd_error       <= 1'b0;
                    end
                end
                SETUP: begin
                    M_AXI_ARADDR  <= base_addr + (32'(element_counter) << 2);
                    M_AXI_ARLEN   <= (remaining > NUM_ELEMENTS_WIDTH'(255)) ? 8'hFF
                                     : 8'(remaining - NUM_ELEMENTS_WIDTH'(1));
                    beat_counter  <= '0;
                    M_AXI_ARVALID <= 1'b1;
                end
                AR_WAIT: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (M_AXI_RVALID) begin
                        M_AXIS_TDATA  <= M_AXI_RDATA;
                        M_AXIS_TVALID <= 1'b1;
                        M_AXI_RREADY  <= 1'b0;
`ifdef RD_RESP_CHECK_EN
                        if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != last_beat)) begin
                            rd_error <= 1'b1;
                        end
`endif
                    end
                end
                PUSH: begin
                    if (M_AXIS_TREADY) begin
                        M_AXIS_TVALID   <= 1'b0;
                        element_counter <= element_counter + 1'b1;
                        beat_counter    <= beat_counter + 1'b1;
                        if (!last_beat) begin
                            M_AXI_RREADY <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (element_counter == total_elements) begin
                        element_counter <= '0;
                        beat_counter    <= '0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
